pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register; successor to the fixed ID/EX latch.
- Carries an opaque payload for LANES parallel lanes (default 1), with a per-lane valid bit and delay-slot tracking.
- Applies the codebase's global stall-vector and flush rules: hold, bubble insertion, flush.
- Instantiated at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) by setting STAGE_IDX; the ID/EX instance feeds the delay-slot flag back to ID.

---
 rtl/pipe_stage_reg_pkg.sv | 33 +++
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the inter-stage pipeline registers: stall-vector stage indices,
// default payload widths per stage boundary and the NOP bubble encoding.
// No logic and no latency; these are constants only.
package pipe_stage_reg_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int STALL_W_DEF = 6;

    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_DATA_W = 112;
    localparam int MEM_WB_DATA_W = 72;

    localparam logic [7:0] ALUOP_NOP  = 8'h00;
    localparam logic [2:0] ALUSEL_NOP = 3'b000;

    typedef struct packed {
        logic [7:0] aluop;
        logic [2:0] alusel;
    } alu_ctl_t;

    localparam alu_ctl_t NOP_CTL = '{aluop: ALUOP_NOP, alusel: ALUSEL_NOP};

    // The NOP control bundle sits in the low bits of the payload; everything above is zero.
    localparam logic [ID_EX_DATA_W-1:0] BUBBLE_VAL_DEF = ID_EX_DATA_W'(NOP_CTL);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones and never wraps.
// Latency: the count updates on the edge after inc is sampled.
// No backpressure; clear has priority over increment.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with per-lane valid, delay-slot tracking and stall/flush rules;
// optional perf counters under PIPE_STAGE_PERF_EN. Latency: one cycle input to output.
// Backpressure via global stall vector: flush > bubble (up only) > hold (up and dn) > load.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = ID_EX_DATA_W,
    parameter int                LANES      = 1,
    parameter int                STALL_W    = STALL_W_DEF,
    parameter int                STAGE_IDX  = STG_ID,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(BUBBLE_VAL_DEF),
    parameter int                CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [STALL_W-1:0]      stall,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_ds_next,
    input  logic                    in_is_ds,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_is_ds,
    output logic                    ds_fb_o,
    output logic                    held_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        bubble_cnt_o
);

    if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
    end

    localparam logic [LANES*DATA_W-1:0] BUBBLE_FILL = {LANES{BUBBLE_VAL}};

    logic up;
    logic dn;

    assign up = stall[STAGE_IDX];
    assign dn = stall[STAGE_IDX+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            out_data  <= BUBBLE_FILL;
            out_is_ds <= 1'b0;
            ds_fb_o   <= 1'b0;
            held_o    <= 1'b0;
        end else if (flush) begin
            out_valid <= '0;
            out_data  <= BUBBLE_FILL;
            out_is_ds <= 1'b0;
            ds_fb_o   <= 1'b0;
            held_o    <= 1'b0;
        end else if (up && !dn) begin
            // Bubble: downstream drains a NOP while ID keeps its pending delay-slot feedback.
            out_valid <= '0;
            out_data  <= BUBBLE_FILL;
            out_is_ds <= 1'b0;
            held_o    <= 1'b0;
        end else if (up && dn) begin
            held_o    <= 1'b1;
        end else begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_is_ds <= in_is_ds;
            ds_fb_o   <= in_ds_next;
            held_o    <= 1'b0;
        end
    end

    // A downstream-only stall would drop the instruction in flight; it is loaded anyway.
    illegal_stall_a: assert property (@(posedge clk) disable iff (!rst) !(dn && !up));

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = up && !flush;
    assign bubble_inc = up && !dn && !flush;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .core_clk (clk),
        .arst_n   (rst),
        .clr      (flush),
        .inc      (stall_inc),
        .cnt      (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .core_clk (clk),
        .arst_n   (rst),
        .clr      (flush),
        .inc      (bubble_inc),
        .cnt      (bubble_cnt_o)
    );
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes model expectations per edge, monitor compares.
// Latency: expectations are checked one edge after stimulus, sampled 1 time unit past the edge.
// Stall patterns are restricted to the legal up/dn combinations.
module tb_pipe_stage_reg;

    localparam int DATA_W    = 16;
    localparam int LANES     = 2;
    localparam int STALL_W   = 6;
    localparam int STAGE_IDX = 2;
    localparam int CNT_W     = 4;
    localparam int DW        = DATA_W * LANES;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] BUB = 16'h0000;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [STALL_W-1:0] stall;
    logic [LANES-1:0]   in_valid;
    logic [DW-1:0]      in_data;
    logic               in_ds_next;
    logic               in_is_ds;
    logic [LANES-1:0]   out_valid;
    logic [DW-1:0]      out_data;
    logic               out_is_ds;
    logic               ds_fb_o;
    logic               held_o;
    logic [CNT_W-1:0]   stall_cnt_o;
    logic [CNT_W-1:0]   bubble_cnt_o;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .STALL_W    (STALL_W),
        .STAGE_IDX  (STAGE_IDX),
        .BUBBLE_VAL (BUB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall        (stall),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ds_next   (in_ds_next),
        .in_is_ds     (in_is_ds),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_is_ds    (out_is_ds),
        .ds_fb_o      (ds_fb_o),
        .held_o       (held_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    typedef struct {
        logic [LANES-1:0] vld;
        logic [DW-1:0]    dat;
        logic             is_ds;
        logic             ds_fb;
        logic             held;
        int               sc;
        int               bc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [LANES-1:0] m_vld;
    logic [DW-1:0]    m_dat;
    logic             m_is_ds, m_ds_fb, m_held;
    int               m_sc, m_bc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_vld   = '0;
        m_dat   = {LANES{BUB}};
        m_is_ds = 1'b0;
        m_ds_fb = 1'b0;
        m_held  = 1'b0;
        m_sc    = 0;
        m_bc    = 0;
    endtask

    // One clock of stimulus; the model is the stall/flush rule table applied to plain variables.
    task automatic step(input logic r, input logic f, input logic [STALL_W-1:0] s,
                        input logic [LANES-1:0] v, input logic [DW-1:0] d,
                        input logic dsn, input logic isds);
        exp_t e;
        logic up, dn;
        @(negedge clk);
        rst = r; flush = f; stall = s; in_valid = v; in_data = d;
        in_ds_next = dsn; in_is_ds = isds;
        up = s[STAGE_IDX];
        dn = s[STAGE_IDX+1];
        if (!r || f) begin
            model_clear();
        end else begin
            if (up) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
            if (up && !dn) begin
                m_bc    = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
                m_vld   = '0;
                m_dat   = {LANES{BUB}};
                m_is_ds = 1'b0;
                m_held  = 1'b0;
            end else if (up) begin
                m_held  = 1'b1;
            end else begin
                m_vld   = v;
                m_dat   = d;
                m_is_ds = isds;
                m_ds_fb = dsn;
                m_held  = 1'b0;
            end
        end
        e.vld = m_vld; e.dat = m_dat; e.is_ds = m_is_ds; e.ds_fb = m_ds_fb;
        e.held = m_held; e.sc = PERF ? m_sc : 0; e.bc = PERF ? m_bc : 0;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_vld"},   64'(out_valid),    64'(0));
        check({tag, "_dat"},   64'(out_data),     64'({LANES{BUB}}));
        check({tag, "_is_ds"}, 64'(out_is_ds),    64'(0));
        check({tag, "_ds_fb"}, 64'(ds_fb_o),      64'(0));
        check({tag, "_held"},  64'(held_o),       64'(0));
        check({tag, "_scnt"},  64'(stall_cnt_o),  64'(0));
        check({tag, "_bcnt"},  64'(bubble_cnt_o), 64'(0));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", 64'(out_valid),    64'(e.vld));
                check("out_data",  64'(out_data),     64'(e.dat));
                check("out_is_ds", 64'(out_is_ds),    64'(e.is_ds));
                check("ds_fb_o",   64'(ds_fb_o),      64'(e.ds_fb));
                check("held_o",    64'(held_o),       64'(e.held));
                check("stall_cnt", 64'(stall_cnt_o),  64'(e.sc));
                check("bubble_cnt",64'(bubble_cnt_o), 64'(e.bc));
            end
        end
    end

    initial begin : driver
        logic [STALL_W-1:0] s;
        rst = 1'b0; flush = 1'b0; stall = '0; in_valid = '0; in_data = '0;
        in_ds_next = 1'b0; in_is_ds = 1'b0;
        model_clear();
        #1;
        check_reset_now("por");

        step(1, 0, 6'b000000, 2'b11, {16'h0011, 16'h0011}, 0, 0);
        step(1, 0, 6'b000000, 2'b01, {16'h0022, 16'h0022}, 0, 0);
        step(1, 0, 6'b000000, 2'b10, {16'h0033, 16'h0033}, 0, 0);

        // Asynchronous reset mid-stream, checked before any edge.
        step(0, 0, 6'b000000, 2'b11, {16'hDEAD, 16'hDEAD}, 0, 0);
        #1;
        check_reset_now("arst");
        step(1, 0, 6'b000000, 2'b11, {16'hDEAD, 16'hDEAD}, 0, 0);

        step(1, 0, 6'b000000, 2'b11, {16'h0055, 16'h0055}, 1, 0);
        step(1, 0, 6'b000111, 2'b11, {16'h0066, 16'h0066}, 0, 1);
        step(1, 1, 6'b000000, 2'b00, {16'h0000, 16'h0000}, 0, 0);
        step(1, 0, 6'b000000, 2'b11, {16'h0044, 16'h0044}, 1, 1);
        repeat (3) step(1, 0, 6'b001111, 2'b11, {16'h0099, 16'h0099}, 0, 0);
        step(1, 1, 6'b001111, 2'b11, {16'h0077, 16'h0077}, 1, 1);

        step(1, 0, 6'b000000, 2'b01, {16'h00B0, 16'h00B0}, 1, 0);
        step(1, 0, 6'b000000, 2'b01, {16'h00B4, 16'h00B4}, 0, 1);

        repeat (20) step(1, 0, 6'b001111, 2'b00, {16'h0123, 16'h0456}, 0, 0);
        step(1, 1, 6'b000000, 2'b00, '0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            s = STALL_W'($urandom);
            case ($urandom_range(0, 2))
                0:       begin s[STAGE_IDX] = 1'b0; s[STAGE_IDX+1] = 1'b0; end
                1:       begin s[STAGE_IDX] = 1'b1; s[STAGE_IDX+1] = 1'b0; end
                default: begin s[STAGE_IDX] = 1'b1; s[STAGE_IDX+1] = 1'b1; end
            endcase
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0), s,
                 LANES'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drain", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
